window_line_buffer_ctrl: RTL
============================

Name: window_line_buffer_ctrl

Overview:
Parametrised successor to the 3-line spatial-filter line buffer controller. Stores NUM_LINES = KERNEL_SIZE+1 image lines in a circular line store and emits one KERNEL_SIZE x KERNEL_SIZE pixel window per image column. Upstream is valid/ready, so the producer is stalled when the store is full. Downstream is valid/ready, so the filter core can stall output. Sits between the DMA/stream input and the convolution core, and raises a per-row interrupt.

Parameters:
IMAGE_WIDTH, 512, pixels per line; must be >= KERNEL_SIZE.
PIXEL_WIDTH, 8, bits per pixel.
KERNEL_SIZE, 3, window height and width; legal values are 3, 5 and 7.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
i_clear  in  1  synchronous clear of pointers, counters and FSM (frame start)
i_pixel_data  in  PIXEL_WIDTH  input pixel, raster order
i_pixel_data_valid  in  1  input pixel valid
o_pixel_ready  out  1  controller can accept a pixel
o_window_data  out  PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE  output window
o_window_valid  out  1  window valid
i_window_ready  in  1  downstream accepts the window
o_intr  out  1  one-cycle pulse per completed output row
o_fill_count  out  clog2(NUM_LINES*IMAGE_WIDTH+1)  pixels currently held

Behaviour:
- Reset is asynchronous and active-high. All of the following are cleared: counters, wr/rd line index, wr/rd column, FSM (to IDLE), o_window_valid, o_window_data, o_intr, o_fill_count. o_pixel_ready = 1 after reset.
- i_clear (synchronous) has the same effect as reset. Line store contents are don't-care after clear.
- Write accept = i_pixel_data_valid && o_pixel_ready.
  - On accept, the pixel is written at [wr_line][wr_col] and wr_col increments.
  - At wr_col == IMAGE_WIDTH-1, wr_col wraps to 0 and wr_line goes to (wr_line+1) mod NUM_LINES.
- o_pixel_ready = (fill_count < NUM_LINES*IMAGE_WIDTH). It is a combinational function of registered fill_count.
- fill_count update each cycle: +1 on write accept, -IMAGE_WIDTH on row release. When both occur in the same cycle, the net change is applied.
- FSM states are IDLE and READ.
  - IDLE -> READ when fill_count >= KERNEL_SIZE*IMAGE_WIDTH. rd_col = 0 on entry.
  - READ -> IDLE on the output handshake of column IMAGE_WIDTH-1.
- Read advance, in READ, when the output register is free: (!o_window_valid || i_window_ready).
  - The window for rd_col is loaded into the output register and o_window_valid is set.
  - rd_col increments.
  - Latency is 1 cycle from advance to valid; sustained throughput is 1 window per clock.
- Output hold: while o_window_valid && !i_window_ready, o_window_data and o_window_valid stay stable.
- o_window_valid clears on a handshake when no new advance occurs in the same cycle.
- Window layout: o_window_data[(r*KERNEL_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = line (rd_line+r) mod NUM_LINES, column rd_col+c.
  - r = 0 is the oldest (top) line.
  - Columns > IMAGE_WIDTH-1 are clamped to IMAGE_WIDTH-1 (edge replication).
- Row release, on the handshake of the final window (column IMAGE_WIDTH-1):
  - rd_line goes to (rd_line+1) mod NUM_LINES.
  - fill_count is reduced by IMAGE_WIDTH.
  - o_intr = 1 for exactly the next cycle.
- Writing the spare (NUM_LINES-th) line is allowed while a row is being read. The oldest read line is never overwritten before release, which is guaranteed by the fill_count limit.
- Pixels arriving while i_pixel_data_valid is high and o_pixel_ready is low are not consumed. The producer holds them.

Optional Feature:
Macro WLB_ZERO_PAD_EN.
- Defined: window columns beyond IMAGE_WIDTH-1 output 0 instead of the replicated edge pixel.
- Undefined: edge replication, as specified in Behaviour.
- No other behaviour changes.

Test Plan:
Bench parameters: KERNEL_SIZE=3, IMAGE_WIDTH=8, PIXEL_WIDTH=8. Pixel value = row*16+col.
1. Stream rows 0-2, i_window_ready=1 -> 8 windows.
   - Window 0: row0 = {0x00,0x01,0x02}, row1 = {0x10,0x11,0x12}, row2 = {0x20,0x21,0x22}.
   - Window 7 (replication): row0 = {0x07,0x07,0x07}.
   - o_intr is high exactly 1 cycle after the 8th handshake; fill_count goes 24 -> 16.
2. Hold i_window_ready=0 for 5 cycles at window 3 -> o_window_data stays the column-3 window and valid stays high. The column-4 window follows with no skip or duplicate.
3. i_window_ready=0, stream continuously -> exactly 32 pixels accepted, then o_pixel_ready=0 with fill_count=32. Release ready -> after the row-0 release, fill_count=24 and o_pixel_ready=1 the next cycle.
4. Stream 10 rows, random i_pixel_data_valid and i_window_ready -> 8 output rows, 8 o_intr pulses. Row n windows use source rows n..n+2 across the line-index wrap.
5. Write accept and row release in the same cycle (fill_count=31) -> fill_count becomes 24.
6. Assert reset mid-row without a clock edge -> o_window_valid, o_intr and o_fill_count are 0 immediately. After deassert, row 0 output restarts cleanly. With WLB_ZERO_PAD_EN defined, window 7 row0 = {0x07,0x00,0x00}.

Source files
------------

// File: rtl/window_line_buffer_ctrl.sv
// rtl/window_line_buffer_ctrl.sv - KxK sliding-window line buffer controller with circular line store
// Optional macro WLB_ZERO_PAD_EN: columns past the right edge read as zero instead of edge replication.
module window_line_buffer_ctrl #(
   parameter  int IMAGE_WIDTH = 512,
   parameter  int PIXEL_WIDTH = 8,
   parameter  int KERNEL_SIZE = 3,
   localparam int NUM_LINES   = KERNEL_SIZE + 1,
   localparam int FILL_W      = $clog2(NUM_LINES*IMAGE_WIDTH+1),
   localparam int WIN_W       = PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_clear,
   input  logic [PIXEL_WIDTH-1:0] i_pixel_data,
   input  logic                   i_pixel_data_valid,
   output logic                   o_pixel_ready,
   output logic [WIN_W-1:0]       o_window_data,
   output logic                   o_window_valid,
   input  logic                   i_window_ready,
   output logic                   o_intr,
   output logic [FILL_W-1:0]      o_fill_count
);

   localparam int LINE_W = $clog2(NUM_LINES);
   localparam int COL_W  = $clog2(IMAGE_WIDTH);
   localparam int RCOL_W = $clog2(IMAGE_WIDTH+1);
   localparam logic [FILL_W-1:0] CAPACITY    = FILL_W'(NUM_LINES*IMAGE_WIDTH);
   localparam logic [FILL_W-1:0] START_LEVEL = FILL_W'(KERNEL_SIZE*IMAGE_WIDTH);
   localparam logic [FILL_W-1:0] ROW_PIX     = FILL_W'(IMAGE_WIDTH);

   typedef enum logic {S_IDLE, S_READ} state_t;

   logic [PIXEL_WIDTH-1:0] r_mem [NUM_LINES][IMAGE_WIDTH];

   state_t            r_state;
   logic [LINE_W-1:0] r_wr_line, r_rd_line;
   logic [COL_W-1:0]  r_wr_col;
   logic [RCOL_W-1:0] r_rd_col;
   logic [FILL_W-1:0] r_fill_count;
   logic [WIN_W-1:0]  r_window_data;
   logic              r_window_valid;
   logic              r_last;
   logic              r_intr;

   logic              w_wr_accept, w_out_free, w_advance, w_handshake, w_release;
   logic [WIN_W-1:0]  w_window;

   assign o_pixel_ready  = r_fill_count < CAPACITY;
   assign o_window_data  = r_window_data;
   assign o_window_valid = r_window_valid;
   assign o_intr         = r_intr;
   assign o_fill_count   = r_fill_count;

   assign w_wr_accept = i_pixel_data_valid && o_pixel_ready;
   assign w_out_free  = !r_window_valid || i_window_ready;
   // rd_col parks at IMAGE_WIDTH once the last column is loaded, until that window is taken
   assign w_advance   = (r_state == S_READ) && (r_rd_col < RCOL_W'(IMAGE_WIDTH)) && w_out_free;
   assign w_handshake = r_window_valid && i_window_ready;
   assign w_release   = w_handshake && r_last;

   always_comb begin
      w_window = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            int line_i;
            int col_i;
            line_i = (int'(r_rd_line) + r) % NUM_LINES;
            col_i  = int'(r_rd_col) + c;
`ifdef WLB_ZERO_PAD_EN
            if (col_i <= IMAGE_WIDTH-1)
               w_window[(r*KERNEL_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = r_mem[LINE_W'(line_i)][COL_W'(col_i)];
`else
            if (col_i > IMAGE_WIDTH-1)
               col_i = IMAGE_WIDTH-1;
            w_window[(r*KERNEL_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = r_mem[LINE_W'(line_i)][COL_W'(col_i)];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_accept)
         r_mem[r_wr_line][r_wr_col] <= i_pixel_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_wr_line      <= '0;
         r_rd_line      <= '0;
         r_wr_col       <= '0;
         r_rd_col       <= '0;
         r_fill_count   <= '0;
         r_window_data  <= '0;
         r_window_valid <= 1'b0;
         r_last         <= 1'b0;
         r_intr         <= 1'b0;
      end else if (i_clear) begin
         r_state        <= S_IDLE;
         r_wr_line      <= '0;
         r_rd_line      <= '0;
         r_wr_col       <= '0;
         r_rd_col       <= '0;
         r_fill_count   <= '0;
         r_window_data  <= '0;
         r_window_valid <= 1'b0;
         r_last         <= 1'b0;
         r_intr         <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            if (r_wr_col == COL_W'(IMAGE_WIDTH-1)) begin
               r_wr_col  <= '0;
               r_wr_line <= (r_wr_line == LINE_W'(NUM_LINES-1)) ? '0 : r_wr_line + 1'b1;
            end else begin
               r_wr_col  <= r_wr_col + 1'b1;
            end
         end

         case ({w_wr_accept, w_release})
            2'b10:   r_fill_count <= r_fill_count + 1'b1;
            2'b01:   r_fill_count <= r_fill_count - ROW_PIX;
            2'b11:   r_fill_count <= r_fill_count + 1'b1 - ROW_PIX;
            default: r_fill_count <= r_fill_count;
         endcase

         r_intr <= w_release;

         if (w_advance) begin
            r_window_data  <= w_window;
            r_window_valid <= 1'b1;
            r_last         <= (r_rd_col == RCOL_W'(IMAGE_WIDTH-1));
            r_rd_col       <= r_rd_col + 1'b1;
         end else if (w_handshake) begin
            r_window_valid <= 1'b0;
            r_last         <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (r_fill_count >= START_LEVEL) begin
                  r_state  <= S_READ;
                  r_rd_col <= '0;
               end
            end
            S_READ: begin
               if (w_release) begin
                  r_state   <= S_IDLE;
                  r_rd_line <= (r_rd_line == LINE_W'(NUM_LINES-1)) ? '0 : r_rd_line + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
